pio_out_pulse: RTL and testbench
================================

// Module: pio_out_pulse
// PURPOSE
//  Parametrised Avalon-MM slave output port driving chip control/address lines (e.g. USB OTG addr/strobes).
//  Adds atomic SET/CLR, a timed self-restoring pulse overlay, sticky status and a completion IRQ.
//  Zero-wait-state slave with combinational readdata. Sits between the Nios II fabric and external pins.
// PARAMETERS
//  DATA_WIDTH    2   out_port width, 1..32
//  RESET_VALUE   0   data_out value at reset
//  PULSE_CNT_W   16  width of PULSE_LEN and the pulse counter, 1..32
//  DEFAULT_PULSE 4   PULSE_LEN reset value (clk cycles)
// PORTS
//  clk          in   1           system clock
//  reset_n      in   1           reset, asynchronous, active-low
//  address      in   3           word offset
//  chipselect   in   1           slave select
//  write_n      in   1           write strobe, active-low
//  writedata    in   32          write data
//  readdata     out  32          read data, combinational from address, zero-extended
//  out_port     out  DATA_WIDTH  pin drive = data_out ^ (busy ? pulse_mask : 0)
//  pulse_busy   out  1           pulse overlay active
//  irq          out  1           done & irq_en
// BEHAVIOUR
//  wr = chipselect & ~write_n. All writes take effect at the next clk edge; no waitrequest.
//  Register map (unused bits read 0; writedata truncated to field width):
//   0 DATA      RW: data_out <= wd[DW-1:0]
//   1 SET       W:  data_out <= data_out | wd; reads 0
//   2 CLR       W:  data_out <= data_out & ~wd; reads 0
//   3 PULSE_LEN RW: len <= wd[PULSE_CNT_W-1:0]
//   4 PULSE     W:  launch pulse with mask wd[DW-1:0]; reads pulse_mask
//   5 STATUS    b0 busy RO; b1 done W1C; b2 overrun W1C; b3 irq_en RW
//   6,7         read 0, writes ignored
//  Reset: data_out=RESET_VALUE, len=DEFAULT_PULSE, pulse_mask=0, cnt=0, busy=0, done=0, overrun=0,
//   irq_en=0. Consequently out_port=RESET_VALUE and pulse_busy=irq=0.
//  Pulse FSM, states IDLE/ACTIVE:
//   IDLE: PULSE write with len!=0 -> latch mask, cnt<=len, -> ACTIVE.
//    busy is high from the cycle after the write for exactly len cycles.
//   IDLE: PULSE write with len==0 -> no action, no flags.
//   ACTIVE: cnt decrements each cycle. When cnt==1 -> IDLE, cnt<=0, done<=1.
//    mask stays latched; the overlay is gated by busy.
//   ACTIVE: PULSE write -> ignored, overrun<=1, pulse continues unchanged.
//   ACTIVE: PULSE_LEN write -> affects the next pulse only.
//  DATA/SET/CLR while ACTIVE update data_out; the overlay XORs on top; restore yields the new data_out.
//  Same-cycle done-set and W1C of done: set wins. Same for overrun.
//  reset_n asserted mid-pulse -> immediate IDLE, all reset values; the pulse is abandoned.
//  mask==0 pulse still runs the timer and sets done, with no pin change.
//  Width rule: cnt is PULSE_CNT_W bits, unsigned; len max 2^PULSE_CNT_W-1 cycles; no wrap.
// STRUCTURE
//  Shared package/include pio_regs_pkg: address constants ADDR_DATA..ADDR_STATUS, STATUS bit indices.
//  Sub-module pio_pulse_timer:
//   in:  start, len, abort
//   out: busy, done_pulse
//   Holds the IDLE/ACTIVE FSM and counter.
//  The top level holds registers, read mux, overlay XOR, status flags.
// TESTING
//  Reset -> out_port=RESET_VALUE, readdata@5=0x0, @3=DEFAULT_PULSE, irq=0.
//  DW=2: write DATA=0x1, SET 0x2, CLR 0x1 -> out_port 1,3,2 on successive cycles; read @0=0x2.
//  len=3, DATA=0, PULSE 0x2 -> out_port=2 for exactly 3 cycles starting 1 cycle after the write, then 0;
//   STATUS b1=1.
//  PULSE during ACTIVE -> pulse length unchanged, STATUS=0x5 (busy+overrun);
//   write 0x4 to STATUS -> overrun cleared.
//  irq_en=1, pulse completes -> irq=1; W1C done in the completion cycle -> done stays 1;
//   a later W1C -> irq=0.
//  len=0 PULSE -> no busy, no done; reset_n low mid-pulse -> out_port=RESET_VALUE immediately,
//   busy=0.

Source files
------------

// File: rtl/pio_regs_pkg.sv
// ============================================================================
// Module   : pio_regs_pkg
// Purpose  : Register offsets and STATUS bit positions for the PIO output port.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pio_regs_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLR       = 3'd2;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
    localparam logic [2:0] ADDR_PULSE     = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_IRQ_EN  = 3;

endpackage

`default_nettype wire

// File: rtl/pio_pulse_timer.sv
// ============================================================================
// Module   : pio_pulse_timer
// Purpose  : IDLE/ACTIVE pulse timer; busy for exactly len cycles after start.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pio_pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done_pulse
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A zero length launches nothing and raises no flags
                if (start && (len != '0)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = len;
                end
            end
            S_ACTIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    done_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == S_ACTIVE);

endmodule

`default_nettype wire

// File: rtl/pio_out_pulse.sv
// ============================================================================
// Module   : pio_out_pulse
// Purpose  : Avalon-MM output port with SET/CLR, timed pulse overlay and IRQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pio_out_pulse
    import pio_regs_pkg::*;
#(
    parameter int          DATA_WIDTH    = 2,
    parameter logic [31:0] RESET_VALUE   = 32'd0,
    parameter int          PULSE_CNT_W   = 16,
    parameter logic [31:0] DEFAULT_PULSE = 32'd4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_busy,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic [PULSE_CNT_W-1:0] len_q, len_d;
    logic [DATA_WIDTH-1:0]  mask_q, mask_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic                   irq_en_q, irq_en_d;

    logic                   w_wr;
    logic                   w_wr_pulse;
    logic                   w_wr_status;
    logic                   w_busy;
    logic                   w_done_pulse;
    logic                   w_launch;
    logic [DATA_WIDTH-1:0]  w_wd;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_pulse  = w_wr & (address == ADDR_PULSE);
    assign w_wr_status = w_wr & (address == ADDR_STATUS);
    assign w_wd        = writedata[DATA_WIDTH-1:0];
    assign w_launch    = w_wr_pulse & ~w_busy & (len_q != '0);

    pio_pulse_timer #(
        .CNT_W (PULSE_CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (w_wr_pulse),
        .len        (len_q),
        .abort      (1'b0),
        .busy       (w_busy),
        .done_pulse (w_done_pulse)
    );

    always_comb begin
        data_out_d = data_out_q;
        len_d      = len_q;
        mask_d     = mask_q;
        irq_en_d   = irq_en_q;
        if (w_wr) begin
            case (address)
                ADDR_DATA:      data_out_d = w_wd;
                ADDR_SET:       data_out_d = data_out_q | w_wd;
                ADDR_CLR:       data_out_d = data_out_q & ~w_wd;
                ADDR_PULSE_LEN: len_d      = writedata[PULSE_CNT_W-1:0];
                ADDR_STATUS:    irq_en_d   = writedata[STAT_IRQ_EN];
                default:        ;
            endcase
        end
        if (w_launch) begin
            mask_d = w_wd;
        end
        // Flag set takes priority over a coincident write-1-to-clear
        done_d    = (done_q & ~(w_wr_status & writedata[STAT_DONE])) | w_done_pulse;
        overrun_d = (overrun_q & ~(w_wr_status & writedata[STAT_OVERRUN])) |
                    (w_wr_pulse & w_busy);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE[DATA_WIDTH-1:0];
            len_q      <= DEFAULT_PULSE[PULSE_CNT_W-1:0];
            mask_q     <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            len_q      <= len_d;
            mask_q     <= mask_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            irq_en_q   <= irq_en_d;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:      readdata = 32'(data_out_q);
            ADDR_PULSE_LEN: readdata = 32'(len_q);
            ADDR_PULSE:     readdata = 32'(mask_q);
            ADDR_STATUS: begin
                readdata[STAT_BUSY]    = w_busy;
                readdata[STAT_DONE]    = done_q;
                readdata[STAT_OVERRUN] = overrun_q;
                readdata[STAT_IRQ_EN]  = irq_en_q;
            end
            default:        readdata = 32'd0;
        endcase
    end

    assign out_port   = data_out_q ^ (w_busy ? mask_q : '0);
    assign pulse_busy = w_busy;
    assign irq        = done_q & irq_en_q;

endmodule

`default_nettype wire

// File: tb/tb_pio_out_pulse.sv
// ============================================================================
// Module   : tb_pio_out_pulse
// Purpose  : Self-checking bench for pio_out_pulse (DATA_WIDTH=2, RESET_VALUE=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pio_out_pulse;

    localparam logic [1:0] RV = 2'b01;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [1:0]  out_port;
    logic        pulse_busy;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          id;
        logic [1:0]  port;
        logic        busy;
        logic        irq;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [2:0]  raddr;
        logic [1:0]  port;
        logic        busy;
        logic        irq;
        logic [31:0] rd;
    } vec_t;

    exp_t sb[$];
    int   step_id = 0;

    pio_out_pulse #(
        .DATA_WIDTH    (2),
        .RESET_VALUE   (32'd1),
        .PULSE_CNT_W   (16),
        .DEFAULT_PULSE (32'd4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_busy (pulse_busy),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
        end
    endtask

    // One clock cycle: optional bus write, then sample outputs with readdata at raddr
    task automatic step(input logic wr, input logic [2:0] addr, input logic [31:0] wd,
                        input logic [2:0] raddr, input logic [1:0] e_port,
                        input logic e_busy, input logic e_irq, input logic [31:0] e_rd);
        exp_t e;
        step_id++;
        address    = addr;
        writedata  = wd;
        chipselect = wr;
        write_n    = ~wr;
        e.id = step_id; e.port = e_port; e.busy = e_busy; e.irq = e_irq; e.rd = e_rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = raddr;
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard empty at step %0d", step_id);
        end else begin
            e = sb.pop_front();
            check("out_port",   e.id, 32'(out_port),   32'(e.port));
            check("pulse_busy", e.id, 32'(pulse_busy), 32'(e.busy));
            check("irq",        e.id, 32'(irq),        32'(e.irq));
            check("readdata",   e.id, readdata,        e.rd);
        end
    endtask

    task automatic idle(input logic [2:0] raddr, input logic [1:0] e_port,
                        input logic e_busy, input logic e_irq, input logic [31:0] e_rd);
        step(1'b0, 3'd0, 32'd0, raddr, e_port, e_busy, e_irq, e_rd);
    endtask

    vec_t vecs[12];

    initial begin
        // Register-access table: {wr, addr, wdata, read addr, port, busy, irq, readdata}
        vecs[0]  = '{1'b1, 3'd0, 32'h1,        3'd0, 2'd1, 1'b0, 1'b0, 32'h1};
        vecs[1]  = '{1'b1, 3'd1, 32'h2,        3'd0, 2'd3, 1'b0, 1'b0, 32'h3};
        vecs[2]  = '{1'b1, 3'd2, 32'h1,        3'd0, 2'd2, 1'b0, 1'b0, 32'h2};
        vecs[3]  = '{1'b1, 3'd1, 32'h0,        3'd1, 2'd2, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 3'd2, 32'h0,        3'd2, 2'd2, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 3'd3, 32'h3,        3'd3, 2'd2, 1'b0, 1'b0, 32'h3};
        vecs[6]  = '{1'b1, 3'd6, 32'hFF,       3'd6, 2'd2, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 3'd7, 32'hFF,       3'd7, 2'd2, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 3'd5, 32'h8,        3'd5, 2'd2, 1'b0, 1'b0, 32'h8};
        vecs[9]  = '{1'b1, 3'd5, 32'h0,        3'd5, 2'd2, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 3'd0, 32'hFFFFFFFD, 3'd0, 2'd1, 1'b0, 1'b0, 32'h1};
        vecs[11] = '{1'b1, 3'd0, 32'h0,        3'd4, 2'd0, 1'b0, 1'b0, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        address = 3'd5; #1;
        check("reset status", 0, readdata, 32'h0);
        address = 3'd3; #1;
        check("reset pulse_len", 0, readdata, 32'd4);
        check("reset out_port", 0, 32'(out_port), 32'(RV));
        check("reset irq", 0, 32'(irq), 32'd0);
        check("reset busy", 0, 32'(pulse_busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].raddr,
                 vecs[i].port, vecs[i].busy, vecs[i].irq, vecs[i].rd);
        end

        // Basic pulse: len=3, DATA=0, mask 0x2 -> three busy cycles then done
        step(1'b1, 3'd4, 32'h2, 3'd5, 2'd2, 1'b1, 1'b0, 32'h1);
        idle(3'd5, 2'd2, 1'b1, 1'b0, 32'h1);
        idle(3'd4, 2'd2, 1'b1, 1'b0, 32'h2);
        idle(3'd5, 2'd0, 1'b0, 1'b0, 32'h2);
        idle(3'd4, 2'd0, 1'b0, 1'b0, 32'h2);
        step(1'b1, 3'd5, 32'h2, 3'd5, 2'd0, 1'b0, 1'b0, 32'h0);

        // Overrun: second PULSE and a PULSE_LEN write during ACTIVE leave this pulse alone
        step(1'b1, 3'd4, 32'h1, 3'd5, 2'd1, 1'b1, 1'b0, 32'h1);
        step(1'b1, 3'd4, 32'h2, 3'd5, 2'd1, 1'b1, 1'b0, 32'h5);
        step(1'b1, 3'd3, 32'h5, 3'd4, 2'd1, 1'b1, 1'b0, 32'h1);
        idle(3'd5, 2'd0, 1'b0, 1'b0, 32'h6);
        step(1'b1, 3'd5, 32'h4, 3'd5, 2'd0, 1'b0, 1'b0, 32'h2);
        step(1'b1, 3'd5, 32'h2, 3'd3, 2'd0, 1'b0, 1'b0, 32'h5);
        step(1'b1, 3'd3, 32'h3, 3'd5, 2'd0, 1'b0, 1'b0, 32'h0);

        // IRQ: W1C of done in the completion cycle loses to the set
        step(1'b1, 3'd5, 32'h8, 3'd5, 2'd0, 1'b0, 1'b0, 32'h8);
        step(1'b1, 3'd4, 32'h1, 3'd5, 2'd1, 1'b1, 1'b0, 32'h9);
        idle(3'd5, 2'd1, 1'b1, 1'b0, 32'h9);
        step(1'b1, 3'd5, 32'hA, 3'd5, 2'd1, 1'b1, 1'b0, 32'h9);
        step(1'b1, 3'd5, 32'hA, 3'd5, 2'd0, 1'b0, 1'b1, 32'hA);
        step(1'b1, 3'd5, 32'hA, 3'd5, 2'd0, 1'b0, 1'b0, 32'h8);
        step(1'b1, 3'd5, 32'h0, 3'd5, 2'd0, 1'b0, 1'b0, 32'h0);

        // DATA write under the overlay: restore yields the new data_out
        step(1'b1, 3'd4, 32'h3, 3'd0, 2'd3, 1'b1, 1'b0, 32'h0);
        step(1'b1, 3'd0, 32'h1, 3'd0, 2'd2, 1'b1, 1'b0, 32'h1);
        idle(3'd0, 2'd2, 1'b1, 1'b0, 32'h1);
        idle(3'd5, 2'd1, 1'b0, 1'b0, 32'h2);
        step(1'b1, 3'd5, 32'h2, 3'd5, 2'd1, 1'b0, 1'b0, 32'h0);

        // Zero-mask pulse: timer runs and sets done, pins unchanged
        step(1'b1, 3'd4, 32'h0, 3'd5, 2'd1, 1'b1, 1'b0, 32'h1);
        idle(3'd5, 2'd1, 1'b1, 1'b0, 32'h1);
        idle(3'd5, 2'd1, 1'b1, 1'b0, 32'h1);
        idle(3'd5, 2'd1, 1'b0, 1'b0, 32'h2);
        step(1'b1, 3'd5, 32'h2, 3'd5, 2'd1, 1'b0, 1'b0, 32'h0);

        // len=0: PULSE does nothing, no flags
        step(1'b1, 3'd3, 32'h0, 3'd3, 2'd1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 3'd4, 32'h3, 3'd5, 2'd1, 1'b0, 1'b0, 32'h0);
        idle(3'd5, 2'd1, 1'b0, 1'b0, 32'h0);

        // Reset mid-pulse: immediate return to reset values
        step(1'b1, 3'd0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 3'd3, 32'h4, 3'd3, 2'd0, 1'b0, 1'b0, 32'h4);
        step(1'b1, 3'd4, 32'h2, 3'd5, 2'd2, 1'b1, 1'b0, 32'h1);
        reset_n = 1'b0;
        address = 3'd5;
        #1;
        check("midreset out_port", 0, 32'(out_port), 32'(RV));
        check("midreset busy", 0, 32'(pulse_busy), 32'd0);
        check("midreset status", 0, readdata, 32'h0);
        address = 3'd4; #1;
        check("midreset mask", 0, readdata, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(3'd0, RV, 1'b0, 1'b0, 32'(RV));

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard leftover entries: got %0d, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
